// File: rtl/write_to_ddr3_if.sv
// Avalon-MM write channel between the frame writer and the DDR3 controller.
interface write_to_ddr3_if;
  logic         ddr3_avl_ready;
  logic         ddr3_avl_burstbegin;
  logic         ddr3_avl_write_req;
  logic [2:0]   ddr3_avl_size;
  logic [25:0]  ddr3_avl_addr;
  logic [127:0] ddr3_avl_wdata;
  logic [15:0]  ddr3_avl_be;

  modport master (
    input  ddr3_avl_ready,
    output ddr3_avl_burstbegin, ddr3_avl_write_req, ddr3_avl_size,
           ddr3_avl_addr, ddr3_avl_wdata, ddr3_avl_be
  );

  modport slave (
    output ddr3_avl_ready,
    input  ddr3_avl_burstbegin, ddr3_avl_write_req, ddr3_avl_size,
           ddr3_avl_addr, ddr3_avl_wdata, ddr3_avl_be
  );
endinterface

// File: rtl/write_to_ddr3.sv
// Ping-pong frame writer: drains a show-ahead FIFO into two DDR3 frame buffers
// as 4-beat bursts, plus a single-word test-write path.
module write_to_ddr3 #(
  parameter int IMAGE_WIDTH      = 1280,
  parameter int IMAGE_HEIGHT     = 1024,
  parameter int BURSTS_PER_FRAME = (IMAGE_WIDTH*IMAGE_HEIGHT)>>2
) (
  input  logic           ddr3_clk,
  input  logic           ddr3_reset_n,
  input  logic [127:0]   src_fifo_data,
  input  logic           src_burst_avail,
  output logic           src_fifo_rd,
  input  logic [25:0]    ddr3_buffer0_offset,
  input  logic [25:0]    ddr3_buffer1_offset,
  input  logic           clear_buffer0,
  input  logic           clear_buffer1,
  output logic           ddr3_buffer0_full,
  output logic           ddr3_buffer1_full,
  input  logic           test_wr,
  input  logic [25:0]    test_addr,
  input  logic [127:0]   test_wr_data,
  output logic           test_wr_done,
  write_to_ddr3_if.master avl
);
  localparam int BCW = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [BCW-1:0] LAST_BURST = BCW'(BURSTS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, TEST_WRITE, WAIT_DATA, WRITE_BURST} state_t;

  state_t         state, state_nxt;
  logic           buf_sel;
  logic [BCW-1:0] burst_cnt;
  logic [1:0]     beat_cnt;
  logic [1:0]     full;
  logic [1:0]     clr;
  logic [25:0]    addr_r;
  logic [2:0]     size_r;
  logic [127:0]   test_data_r;
  logic           sel_free, accept, burst_done, frame_done;

  assign clr        = {clear_buffer1, clear_buffer0};
  // A clear arriving this cycle already frees the buffer, so the stall ends immediately.
  assign sel_free   = !full[buf_sel] || clr[buf_sel];
  assign accept     = avl.ddr3_avl_write_req && avl.ddr3_avl_ready;
  assign burst_done = (state == WRITE_BURST) && accept && (beat_cnt == 2'd3);
  assign frame_done = burst_done && (burst_cnt == LAST_BURST);

  assign ddr3_buffer0_full = full[0];
  assign ddr3_buffer1_full = full[1];
  assign avl.ddr3_avl_addr = addr_r;
  assign avl.ddr3_avl_size = size_r;
  assign avl.ddr3_avl_be   = 16'hFFFF;

  always_comb begin
    state_nxt               = state;
    avl.ddr3_avl_write_req  = 1'b0;
    avl.ddr3_avl_burstbegin = 1'b0;
    avl.ddr3_avl_wdata      = '0;
    src_fifo_rd             = 1'b0;
    case (state)
      IDLE: begin
        if (test_wr)       state_nxt = TEST_WRITE;
        else if (sel_free) state_nxt = WAIT_DATA;
      end
      TEST_WRITE: begin
        avl.ddr3_avl_write_req  = 1'b1;
        avl.ddr3_avl_burstbegin = 1'b1;
        avl.ddr3_avl_wdata      = test_data_r;
        if (avl.ddr3_avl_ready) state_nxt = IDLE;
      end
      WAIT_DATA: begin
        if (src_burst_avail) state_nxt = WRITE_BURST;
      end
      WRITE_BURST: begin
        avl.ddr3_avl_write_req  = 1'b1;
        avl.ddr3_avl_burstbegin = (beat_cnt == 2'd0);
        avl.ddr3_avl_wdata      = src_fifo_data;
        src_fifo_rd             = avl.ddr3_avl_ready;
        if (burst_done) state_nxt = frame_done ? IDLE : WAIT_DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state        <= IDLE;
      buf_sel      <= 1'b0;
      burst_cnt    <= '0;
      beat_cnt     <= '0;
      addr_r       <= '0;
      size_r       <= '0;
      test_data_r  <= '0;
      test_wr_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      test_wr_done <= (state == TEST_WRITE) && avl.ddr3_avl_ready;
      case (state)
        IDLE: begin
          if (test_wr) begin
            addr_r      <= test_addr;
            test_data_r <= test_wr_data;
            size_r      <= 3'd1;
          end else if (sel_free) begin
            // Offsets are captured only here, so mid-frame changes wait for the next frame.
            addr_r    <= buf_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
            size_r    <= 3'd4;
            burst_cnt <= '0;
          end
        end
        WAIT_DATA: if (src_burst_avail) beat_cnt <= '0;
        WRITE_BURST: begin
          if (accept) beat_cnt <= beat_cnt + 2'd1;
          if (frame_done) begin
            buf_sel <= ~buf_sel;
          end else if (burst_done) begin
            addr_r    <= addr_r + 26'd4;
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame completion beats a coincident clear on the same buffer.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      full <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (frame_done && (buf_sel == i[0])) full[i] <= 1'b1;
        else if (clr[i])                     full[i] <= 1'b0;
      end
    end
  end
endmodule
